// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: drains one router FIFO into a valid/ready byte stream with sop/eop, parity check and stall timeout.
// Optional parity checking is built when FIFO_PKT_READER_PARITY_CHECK_EN is defined.
module fifo_pkt_reader #(
  parameter int TIMEOUT = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       soft_reset,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       fifo_read_enb,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic [1:0] pkt_addr,
  output logic       parity_err,
  output logic       timeout_rst,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PARITY} state_t;
  state_t state, state_nxt;
  logic inflight, par_popped, accept, stalled, timeout, abort, pop;
  logic [5:0] cnt;
  logic [7:0] stall;
  assign accept = dout_valid & dout_ready;
  assign stalled = dout_valid & !dout_ready;
  assign timeout = stalled & (stall == 8'(TIMEOUT - 1));
  assign abort = soft_reset | timeout;
  // A pop needs the output slot to be free by the capture edge, so pops and captures alternate
  assign pop = !reset & !fifo_empty & !inflight & (!dout_valid | dout_ready) & !abort & !(state == PARITY & par_popped);
  assign fifo_read_enb = pop;
  assign busy = state != IDLE;
  always_comb begin
    state_nxt = state;
    if (abort) state_nxt = IDLE;
    else if (state == IDLE && pop) state_nxt = HDR;
    else if (state == HDR && inflight) state_nxt = fifo_data[7:2] == 6'd0 ? PARITY : PAYLOAD;
    else if (state == PAYLOAD && inflight && cnt == 6'd1) state_nxt = PARITY;
    else if (state == PARITY && accept && dout_eop) state_nxt = IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      inflight <= 1'b0;
      par_popped <= 1'b0;
      cnt <= 6'd0;
      stall <= 8'd0;
      dout <= 8'h00;
      dout_valid <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      pkt_addr <= 2'b00;
      timeout_rst <= 1'b0;
    end else begin
      state <= state_nxt;
      stall <= stalled & !abort ? stall + 8'd1 : 8'd0;
      timeout_rst <= timeout;
      if (abort) begin
        inflight <= 1'b0;
        par_popped <= 1'b0;
        cnt <= 6'd0;
        dout_valid <= 1'b0;
        dout_sop <= 1'b0;
        dout_eop <= 1'b0;
      end else begin
        inflight <= pop;
        par_popped <= (state_nxt == PARITY) & (par_popped | (pop & state == PARITY));
        if (inflight) begin
          dout <= fifo_data;
          dout_valid <= 1'b1;
          dout_sop <= state == HDR;
          dout_eop <= state == PARITY;
        end else if (accept) begin
          dout_valid <= 1'b0;
          dout_sop <= 1'b0;
          dout_eop <= 1'b0;
        end
        if (inflight && state == HDR) begin
          cnt <= fifo_data[7:2];
          pkt_addr <= fifo_data[1:0];
        end else if (inflight && state == PAYLOAD) cnt <= cnt - 6'd1;
      end
    end
`ifdef FIFO_PKT_READER_PARITY_CHECK_EN
  logic [7:0] acc;
  // dout still holds the parity byte when it is accepted, so compare there
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      acc <= 8'h00;
      parity_err <= 1'b0;
    end else begin
      parity_err <= !abort & accept & dout_eop & (acc != dout);
      acc <= abort ? 8'h00 : inflight & state == HDR ? fifo_data : inflight & state == PAYLOAD ? acc ^ fifo_data : acc;
    end
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb_fifo_pkt_reader: randomized self-checking bench for fifo_pkt_reader against a packet-level model.
module tb_fifo_pkt_reader;
  logic clock = 0, reset = 1, soft_reset = 0, dout_ready = 1;
  logic fifo_empty, fifo_read_enb, dout_valid, dout_sop, dout_eop, parity_err, timeout_rst, busy;
  logic [7:0] fifo_data = 8'h00, dout;
  logic [1:0] pkt_addr;
  int checks = 0, errors = 0;
  logic [7:0] mem [0:4095];
  logic [11:0] wr_ptr = 0, rd_ptr = 0;
  logic [7:0] exp_b[$], got_b[$];
  bit exp_s[$], exp_e[$], got_s[$], got_e[$];
  int exp_perr, exp_cyc;
  logic [1:0] exp_addr;
  int perr_cnt, perr_on_eop, to_cnt, busy_cyc, held_changes, stall_pops, stall_done;

  fifo_pkt_reader dut (
    .clock(clock), .reset(reset), .soft_reset(soft_reset), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_read_enb(fifo_read_enb), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_sop(dout_sop), .dout_eop(dout_eop), .pkt_addr(pkt_addr),
    .parity_err(parity_err), .timeout_rst(timeout_rst), .busy(busy)
  );

  always #5 clock = ~clock;
  assign fifo_empty = wr_ptr == rd_ptr;
  always @(posedge clock)
    if (fifo_read_enb) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 12'd1;
    end

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 12'd1;
  endtask

  task automatic clear_exp();
    exp_b.delete(); exp_s.delete(); exp_e.delete();
    exp_perr = 0;
    exp_cyc = 0;
  endtask

  // Packet model: header {len,addr}, len random bytes, XOR of all preceding bytes (optionally corrupted)
  task automatic make_pkt(input logic [1:0] addr, input logic [5:0] len, input bit bad);
    logic [7:0] b, p;
    b = {len, addr};
    p = b;
    push(b); exp_b.push_back(b); exp_s.push_back(1); exp_e.push_back(0);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      p ^= b;
      push(b); exp_b.push_back(b); exp_s.push_back(0); exp_e.push_back(0);
    end
    b = p ^ {7'd0, bad};
    push(b); exp_b.push_back(b); exp_s.push_back(0); exp_e.push_back(1);
`ifdef FIFO_PKT_READER_PARITY_CHECK_EN
    if (bad) exp_perr++;
`endif
    exp_addr = addr;
    exp_cyc += 2 * (int'(len) + 2);
  endtask

  // Drives dout_ready and records accepted bytes plus side observations until npkt eops are taken
  task automatic run(input int npkt, input int stall_at, input int stall_len, input bit rnd);
    int eops = 0;
    bit after_eop = 0;
    logic [7:0] held = 8'h00;
    got_b.delete(); got_s.delete(); got_e.delete();
    perr_cnt = 0; perr_on_eop = 0; to_cnt = 0; busy_cyc = 0;
    held_changes = 0; stall_pops = 0; stall_done = 0;
    for (int g = 0; g < 3000 && (eops < npkt || after_eop); g++) begin
      @(negedge clock);
      if (parity_err) begin
        perr_cnt++;
        if (after_eop) perr_on_eop++;
      end
      after_eop = 0;
      if (timeout_rst) to_cnt++;
      if (busy) busy_cyc++;
      if (dout_valid && got_b.size() == stall_at && stall_done < stall_len) begin
        if (stall_done > 0 && dout !== held) held_changes++;
        held = dout;
        dout_ready = 0;
        stall_done++;
        #1 if (fifo_read_enb) stall_pops++;
      end else dout_ready = rnd ? ($urandom_range(0, 9) < 7) : 1'b1;
      if (dout_valid && dout_ready) begin
        got_b.push_back(dout); got_s.push_back(dout_sop); got_e.push_back(dout_eop);
        if (dout_eop) begin
          eops++;
          after_eop = 1;
        end
      end
    end
    dout_ready = 1;
  endtask

  task automatic test_reset();
    int n = 0;
    repeat (2) @(negedge clock);
    checks++;
    if ({fifo_read_enb, dout, dout_valid, dout_sop, dout_eop, pkt_addr, parity_err, timeout_rst, busy} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %b expected all zero", {fifo_read_enb, dout, dout_valid, dout_sop, dout_eop, pkt_addr, parity_err, timeout_rst, busy});
    end
    reset = 0;
    push(8'h4d);
    repeat (4) push(8'($urandom));
    dout_ready = 1;
    for (int k = 0; k < 100 && n < 5; k++) begin
      @(negedge clock);
      if (dout_valid && dout_ready) n++;
    end
    @(negedge clock);
    checks++;
    if (n != 5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_midpkt_setup: got %0d bytes busy=%b expected 5 bytes busy=1", n, busy);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({fifo_read_enb, dout, dout_valid, dout_sop, dout_eop, pkt_addr, parity_err, timeout_rst, busy} !== '0) begin
      errors++;
      $display("FAIL reset_async: got %b expected all zero", {fifo_read_enb, dout, dout_valid, dout_sop, dout_eop, pkt_addr, parity_err, timeout_rst, busy});
    end
    clear_exp();
    make_pkt(2'b01, 6'd9, 0);
    @(negedge clock);
    checks++;
    if (fifo_read_enb !== 1'b0 || fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pop: got read_enb=%b empty=%b expected read_enb=0 empty=0", fifo_read_enb, fifo_empty);
    end
    reset = 0;
    run(1, -1, 0, 0);
    checks++;
    if (got_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL reset_next_count: got %0d bytes expected %0d", got_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
        errors++;
        $display("FAIL reset_next_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_good_packet();
    clear_exp();
    make_pkt(2'b01, 6'd9, 0);
    run(1, -1, 0, 0);
    checks++;
    if (got_b.size() != 11 || exp_b[0] !== 8'h25) begin
      errors++;
      $display("FAIL good_count: got %0d bytes header %h expected 11 bytes header 25", got_b.size(), exp_b[0]);
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
        errors++;
        $display("FAIL good_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (pkt_addr !== 2'b01 || perr_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL good_status: got addr=%b perr=%0d busy=%b expected addr=01 perr=0 busy=0", pkt_addr, perr_cnt, busy);
    end
    checks++;
    if (busy_cyc != 22) begin
      errors++;
      $display("FAIL good_cycles: got %0d expected 22", busy_cyc);
    end
  endtask

  task automatic test_bad_parity();
    clear_exp();
    make_pkt(2'b01, 6'd9, 1);
    run(1, -1, 0, 0);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
        errors++;
        $display("FAIL bad_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (perr_cnt != exp_perr || perr_on_eop != exp_perr) begin
      errors++;
      $display("FAIL bad_parity_err: got %0d pulses (%0d at accept) expected %0d", perr_cnt, perr_on_eop, exp_perr);
    end
  endtask

  task automatic test_zero_len();
    clear_exp();
    make_pkt(2'b10, 6'd0, 0);
    run(1, -1, 0, 0);
    checks++;
    if (got_b.size() != 2 || exp_b[1] !== 8'h02) begin
      errors++;
      $display("FAIL zero_count: got %0d bytes expected 2", got_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
        errors++;
        $display("FAIL zero_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (perr_cnt != 0 || busy_cyc != 4 || pkt_addr !== 2'b10) begin
      errors++;
      $display("FAIL zero_status: got perr=%0d cycles=%0d addr=%b expected perr=0 cycles=4 addr=10", perr_cnt, busy_cyc, pkt_addr);
    end
  endtask

  task automatic test_backpressure();
    clear_exp();
    make_pkt(2'b01, 6'd9, 0);
    run(1, 3, 10, 0);
    checks++;
    if (got_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d bytes expected %0d", got_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
        errors++;
        $display("FAIL bp_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (stall_done != 10 || held_changes != 0 || stall_pops != 0 || to_cnt != 0) begin
      errors++;
      $display("FAIL bp_hold: got stalls=%0d changes=%0d pops=%0d timeouts=%0d expected 10 0 0 0", stall_done, held_changes, stall_pops, to_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_exp();
    for (int p = 0; p < 3; p++) make_pkt(2'($urandom), 6'($urandom_range(0, 12)), 0);
    run(3, -1, 0, 0);
    checks++;
    if (got_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d bytes expected %0d", got_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
        errors++;
        $display("FAIL b2b_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
      end
    end
    checks++;
    if (busy_cyc != exp_cyc || pkt_addr !== exp_addr || perr_cnt != 0) begin
      errors++;
      $display("FAIL b2b_status: got cycles=%0d addr=%b perr=%0d expected cycles=%0d addr=%b perr=0", busy_cyc, pkt_addr, perr_cnt, exp_cyc, exp_addr);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    push(8'h25);
    dout_ready = 0;
    for (int k = 0; k < 20 && !dout_valid; k++) @(negedge clock);
    checks++;
    if (dout_valid !== 1'b1 || dout_sop !== 1'b1) begin
      errors++;
      $display("FAIL to_start: got valid=%b sop=%b expected 1 1", dout_valid, dout_sop);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      n++;
      if (timeout_rst) break;
    end
    checks++;
    if (n != 30) begin
      errors++;
      $display("FAIL to_latency: got %0d cycles expected 30", n);
    end
    checks++;
    if ({dout_valid, dout_sop, busy} !== 3'b000 || pkt_addr !== 2'b01) begin
      errors++;
      $display("FAIL to_abort: got valid=%b sop=%b busy=%b addr=%b expected 0 0 0 01", dout_valid, dout_sop, busy, pkt_addr);
    end
    @(negedge clock);
    checks++;
    if (timeout_rst !== 1'b0) begin
      errors++;
      $display("FAIL to_pulse: got timeout_rst=%b expected 0", timeout_rst);
    end
    dout_ready = 1;
  endtask

  task automatic test_soft_reset();
    int n = 0;
    push(8'h1a);
    repeat (2) push(8'($urandom));
    dout_ready = 1;
    for (int k = 0; k < 50 && n < 3; k++) begin
      @(negedge clock);
      if (dout_valid && dout_ready) n++;
    end
    @(negedge clock);
    checks++;
    if (n != 3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL sr_setup: got %0d bytes busy=%b expected 3 bytes busy=1", n, busy);
    end
    soft_reset = 1;
    @(negedge clock);
    soft_reset = 0;
    checks++;
    if ({dout_valid, busy, timeout_rst} !== 3'b000 || pkt_addr !== 2'b10) begin
      errors++;
      $display("FAIL sr_abort: got valid=%b busy=%b to=%b addr=%b expected 0 0 0 10", dout_valid, busy, timeout_rst, pkt_addr);
    end
    n = 0;
    repeat (35) begin
      @(negedge clock);
      if (timeout_rst) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL sr_no_timeout: got %0d pulses expected 0", n);
    end
    // Corrupt-parity packet whose parity byte is accepted in the abort cycle
    push(8'h03);
    push(8'h00);
    for (int k = 0; k < 20 && !(dout_valid && dout_eop); k++) @(negedge clock);
    soft_reset = 1;
    @(negedge clock);
    soft_reset = 0;
    checks++;
    if (parity_err !== 1'b0 || busy !== 1'b0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL sr_abort_beats_accept: got perr=%b busy=%b valid=%b expected 0 0 0", parity_err, busy, dout_valid);
    end
    clear_exp();
    make_pkt(2'($urandom), 6'($urandom_range(0, 10)), 0);
    run(1, -1, 0, 0);
    checks++;
    if (got_b.size() != exp_b.size()) begin
      errors++;
      $display("FAIL sr_next_count: got %0d bytes expected %0d", got_b.size(), exp_b.size());
    end
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
      checks++;
      if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
        errors++;
        $display("FAIL sr_next_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      clear_exp();
      for (int p = 0; p < 4; p++) make_pkt(2'($urandom), 6'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
      run(4, -1, 0, 1);
      checks++;
      if (got_b.size() != exp_b.size()) begin
        errors++;
        $display("FAIL rnd%0d_count: got %0d bytes expected %0d", r, got_b.size(), exp_b.size());
      end
      for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
        checks++;
        if ({got_b[i], got_s[i], got_e[i]} !== {exp_b[i], exp_s[i], exp_e[i]}) begin
          errors++;
          $display("FAIL rnd%0d_byte[%0d]: got %h sop=%0d eop=%0d expected %h sop=%0d eop=%0d", r, i, got_b[i], got_s[i], got_e[i], exp_b[i], exp_s[i], exp_e[i]);
        end
      end
      checks++;
      if (perr_cnt != exp_perr || perr_on_eop != exp_perr || to_cnt != 0 || pkt_addr !== exp_addr) begin
        errors++;
        $display("FAIL rnd%0d_status: got perr=%0d/%0d to=%0d addr=%b expected perr=%0d to=0 addr=%b", r, perr_cnt, perr_on_eop, to_cnt, pkt_addr, exp_perr, exp_addr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_zero_len();
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_soft_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_pkt_reader.md
# fifo_pkt_reader

Read-side drain engine for one router output FIFO. It pops bytes from the FIFO's data port and parses the router packet format: header `{payload_len[5:0], addr[1:0]}`, then `payload_len` payload bytes, then one parity byte. It presents each byte on a valid/ready stream with start/end-of-packet marks. It also checks byte-wise XOR parity and raises a soft reset toward the FIFO when the downstream consumer stalls too long.

## Interface
- `TIMEOUT`, 30: number of consecutive stalled cycles (`dout_valid` high, `dout_ready` low) that triggers an abort; legal range 1–255.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `soft_reset`  in  1  synchronous abort from the router FSM; same effect as a timeout abort except that `timeout_rst` is not pulsed.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  8  FIFO data output; valid the cycle after a pop.
- `fifo_read_enb`  out  1  pop request (combinational from registered state).
- `dout`  out  8  output byte.
- `dout_valid`  out  1  `dout` holds a byte.
- `dout_ready`  in  1  consumer accepts the byte this cycle.
- `dout_sop`  out  1  `dout` is the header byte.
- `dout_eop`  out  1  `dout` is the parity byte.
- `pkt_addr`  out  2  address field of the current packet; held until the next header is captured.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch.
- `timeout_rst`  out  1  one-cycle pulse to the FIFO's `soft_reset` on timeout.
- `busy`  out  1  high from header pop until parity byte acceptance or abort.

## Operation
- **States:**
  - IDLE → HDR on the first pop.
  - HDR → PAYLOAD on header capture, or HDR → PARITY if `payload_len` = 0.
  - PAYLOAD → PARITY after `payload_len` payload bytes have been captured.
  - PARITY → IDLE on acceptance of the parity byte.
- **Pop rule:** `fifo_read_enb` = !`fifo_empty` & !`inflight` & (!`dout_valid` | `dout_ready`) & !abort & (state ≠ PARITY or parity not yet popped).
  - `inflight` is set on a pop edge and cleared on the capture edge.
  - `fifo_read_enb` is never asserted while `reset` is high.
- **Capture:** on the edge after a pop, `fifo_data` → `dout` and `dout_valid` is set. `dout_sop` is set for the header; `dout_eop` is set for the parity byte.
  - `dout`, `dout_sop` and `dout_eop` stay stable while `dout_valid` & !`dout_ready`.
- **Payload counter:** 6-bit down counter loaded from `fifo_data[7:2]` at header capture and decremented on each payload capture. PAYLOAD → PARITY when it reaches 0.
- **Parity accumulator:** 8-bit XOR. Loaded with the header byte and XORed with each payload byte.
  - At parity capture, if accumulator ≠ parity byte, `parity_err` pulses on the cycle the parity byte is accepted.
- **Abort:** triggered by `soft_reset`, or by the stall counter reaching `TIMEOUT`. On the next edge:
  - state → IDLE;
  - `dout_valid`, `dout_sop`, `dout_eop`, `busy` → 0;
  - the counter and accumulator are cleared;
  - `timeout_rst` pulses for one cycle (timeout only).
  - Any in-flight capture is discarded. `pkt_addr` is kept.
- **Stall counter:** 8-bit. Increments while `dout_valid` & !`dout_ready`; clears on accept or when `dout_valid` is low.
- **Simultaneous events:**
  - Abort beats accept: a byte accepted in the abort cycle is still consumed by downstream, but no parity check is made.
  - A `dout_ready` accept and a new pop may occur in the same cycle.
- The FIFO is trusted to be non-empty mid-packet only eventually. An empty FIFO mid-packet simply stalls the reader; it does not trigger a timeout.

## Timing
- **Reset values:** every output is 0 (`dout` = 8'h00, `pkt_addr` = 2'b00); state IDLE.
- **Latency:** pop at edge E; `fifo_data` valid after E; captured at E+1; `dout_valid` high in the cycle after E+1.
- **Throughput:** at most 1 byte per 2 cycles. A packet of `payload_len` N takes ≥ 2(N+2) cycles with `dout_ready` tied high.
- `timeout_rst` rises exactly `TIMEOUT` cycles after `dout_valid` first goes high without `dout_ready`.
- `parity_err` and the clearing of `busy` happen on the same edge: the parity accept edge.

## Configuration
- `FIFO_PKT_READER_PARITY_CHECK_EN`
  - **Defined:** the accumulator and comparison are built and `parity_err` behaves as above.
  - **Undefined:** the accumulator is removed, `parity_err` is tied to 0, and the parity byte is still forwarded with `dout_eop`.

## Test plan
- **Reset:** `reset` pulse mid-packet (after 4 payload bytes) → all outputs 0 immediately; `fifo_read_enb` 0; next header parsed cleanly.
- **Good packet:** FIFO holds 8'h25 (len 9, addr 01), 9 payload bytes, correct XOR parity; `dout_ready`=1 → 11 bytes out, `dout_sop` on 8'h25, `dout_eop` on the 11th byte, `pkt_addr`=01, `parity_err`=0, 22 cycles.
- **Bad parity:** same packet with the parity byte XOR 8'h01 → single `parity_err` pulse coincident with the parity accept (macro defined); no pulse with the macro undefined.
- **Zero length:** header 8'h02 then parity 8'h02 → 2 bytes out, `sop` then `eop`, no error.
- **Backpressure:** `dout_ready` low for 10 cycles on payload byte 3 → `dout` is held stable, no further pops, no timeout; resumes with byte 4.
- **Timeout:** `dout_ready` held low from the header → `timeout_rst` pulses at cycle 30; `dout_valid` drops and state returns to IDLE. Also `soft_reset` mid-packet → same abort with no `timeout_rst` pulse.
